// File: rtl/hazard_unit_pkg.sv
// Shared pipeline definitions: forward-select encodings, the x0 register
// constant, the shadow-stage record and small helpers used by the hazard
// unit and by the Execute-stage operand multiplexers.
package hazard_unit_pkg;

    // Register-index width of the RV32 register file.
    localparam int REG_W = 5;

    // Architectural zero register: never written, never forwarded.
    localparam logic [REG_W-1:0] REG_X0 = 5'd0;

    // Operand source selects for the Execute operand muxes.
    //   FWD_RD1 : value read from the register file in Decode
    //   FWD_W   : resultW, the value being written back this cycle
    //   FWD_M   : ALU result held in the Memory stage
    typedef enum logic [1:0] {
        FWD_RD1 = 2'b00,
        FWD_W   = 2'b01,
        FWD_M   = 2'b10
    } fwd_sel_e;

    // What the hazard unit remembers about an instruction that has left
    // Execute: which register it targets and whether it really writes it.
    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic             reg_write;
    } shadow_t;

    // True when a later stage will write the register that rs reads.
    // x0 never matches, so it can neither forward nor be a hazard source.
    function automatic logic writes_reg(
        input logic [REG_W-1:0] rd,
        input logic             reg_write,
        input logic [REG_W-1:0] rs
    );
        return reg_write && (rd != REG_X0) && (rd == rs);
    endfunction

    // Execute operand multiplexer driven by a forward select. Kept here so
    // the datapath decodes exactly the encoding the hazard unit produces.
    function automatic logic [31:0] fwd_operand(
        input logic [1:0]  sel,
        input logic [31:0] rd_val,
        input logic [31:0] result_w,
        input logic [31:0] alu_m
    );
        case (sel)
            FWD_W:   return result_w;
            FWD_M:   return alu_m;
            default: return rd_val;
        endcase
    endfunction

endpackage

// File: rtl/fwd_sel.sv
// Forward-source select for one Execute operand. Memory has priority over
// Writeback because it holds the younger producer of the register.
module fwd_sel
    import hazard_unit_pkg::*;
(
    input  logic [REG_W-1:0] RdM,
    input  logic             RegWriteM,
    input  logic [REG_W-1:0] RdW,
    input  logic             RegWriteW,
    input  logic [REG_W-1:0] RsE,
    output logic [1:0]       sel
);

    // Pick the youngest in-flight producer of RsE, else the register file.
    always_comb begin
        sel = FWD_RD1;
        if (writes_reg(RdM, RegWriteM, RsE)) begin
            sel = FWD_M;
        end else if (writes_reg(RdW, RegWriteW, RsE)) begin
            sel = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Hazard unit for a five-stage in-order pipeline: operand forwarding,
// load-use stall, branch/jump flush and stall/flush event counters.
//
// The unit shadows the destination and write-enable of the instructions in
// Memory and Writeback itself, so the datapath only has to present the
// Decode and Execute fields. All hazard outputs are combinational from the
// current inputs and that shadow state. While rst is high every output is
// forced to zero so a stall or flush in progress is dropped immediately.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] Rs1D,
    input  logic [REG_W-1:0] Rs2D,
    input  logic [REG_W-1:0] Rs1E,
    input  logic [REG_W-1:0] Rs2E,
    input  logic [REG_W-1:0] RdE,
    input  logic             RegWriteE,
    input  logic             LoadE,
    input  logic             PCSrcE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Shadow copies of the Memory and Writeback stage destinations.
    shadow_t mem_q;
    shadow_t wb_q;

    // Set when the previous edge flushed ID/EX: the instruction now sitting
    // in Execute is a bubble and must not become a forwarding source.
    logic flush_e_q;

    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       lw_stall;

    fwd_sel u_fwd_a (
        .RdM       (mem_q.rd),
        .RegWriteM (mem_q.reg_write),
        .RdW       (wb_q.rd),
        .RegWriteW (wb_q.reg_write),
        .RsE       (Rs1E),
        .sel       (fwd_a)
    );

    fwd_sel u_fwd_b (
        .RdM       (mem_q.rd),
        .RegWriteM (mem_q.reg_write),
        .RdW       (wb_q.rd),
        .RegWriteW (wb_q.reg_write),
        .RsE       (Rs2E),
        .sel       (fwd_b)
    );

    // Load-use detection plus stall/flush arbitration; a redirect wins over
    // a load-use stall because the dependent instruction is discarded anyway.
    always_comb begin
        lw_stall  = LoadE && (writes_reg(RdE, RegWriteE, Rs1D) ||
                              writes_reg(RdE, RegWriteE, Rs2D));
        ForwardAE = FWD_RD1;
        ForwardBE = FWD_RD1;
        StallF    = 1'b0;
        StallD    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        if (!rst) begin
            ForwardAE = fwd_a;
            ForwardBE = fwd_b;
            if (PCSrcE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (lw_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    // Advance the shadow pipeline; EX/MEM and MEM/WB never stall, and a
    // squashed Execute slot enters Memory with its write-enable cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q     <= '0;
            wb_q      <= '0;
            flush_e_q <= 1'b0;
        end else begin
            mem_q.rd        <= RdE;
            mem_q.reg_write <= RegWriteE && !flush_e_q;
            wb_q            <= mem_q;
            flush_e_q       <= FlushE;
        end
    end

    // Saturating event counters: stall cycles and taken redirects.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (StallF && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_q <= stall_cnt_q + CNT_ONE;
            end
            if (PCSrcE && (flush_cnt_q != CNT_MAX)) begin
                flush_cnt_q <= flush_cnt_q + CNT_ONE;
            end
        end
    end

    // Counters read as zero while reset is held, like every other output.
    assign stall_cnt = rst ? '0 : stall_cnt_q;
    assign flush_cnt = rst ? '0 : flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed scenarios plus a randomized run, all
// checked against a behavioural model that tracks retired writers in a
// queue and counts stall/flush events as plain integers.
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE;
    logic       RegWriteE, LoadE, PCSrcE;

    logic [1:0]  ForwardAE, ForwardBE;
    logic        StallF, StallD, FlushD, FlushE;
    logic [15:0] stall_cnt, flush_cnt;

    logic [1:0] fa4, fb4;
    logic       sf4, sd4, fd4, fe4;
    logic [3:0] stall_cnt4, flush_cnt4;

    int checks = 0;
    int errors = 0;

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    hazard_unit #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .RegWriteE(RegWriteE), .LoadE(LoadE), .PCSrcE(PCSrcE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_unit #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .RegWriteE(RegWriteE), .LoadE(LoadE), .PCSrcE(PCSrcE),
        .ForwardAE(fa4), .ForwardBE(fb4),
        .StallF(sf4), .StallD(sd4), .FlushD(fd4), .FlushE(fe4),
        .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic       wr;
        logic [4:0] rd;
    } writer_t;

    writer_t writers[$];       // [0] = in Memory, [1] = in Writeback
    logic    mdl_prev_flush;   // Execute slot is a bubble this cycle
    int      mdl_stalls;
    int      mdl_flushes;

    function automatic logic [1:0] mdl_fwd(input logic [4:0] rs);
        if (rs == 5'd0) return 2'b00;
        for (int i = 0; i < 2; i++) begin
            if (writers[i].wr && writers[i].rd == rs) return (i == 0) ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    function automatic logic mdl_load_use();
        return LoadE && RegWriteE && (RdE != 5'd0) && (RdE == Rs1D || RdE == Rs2D);
    endfunction

    function automatic int sat(input int n, input int max);
        return (n > max) ? max : n;
    endfunction

    // expected {A, B, StallF, StallD, FlushD, FlushE, cnt16 x2, same for CNT_W=4}
    function automatic logic [55:0] mdl_expect();
        logic [1:0] fa, fb;
        logic       sf, fd, fe;
        int         s16, f16, s4, f4;
        if (rst) return '0;
        fa  = mdl_fwd(Rs1E);
        fb  = mdl_fwd(Rs2E);
        fd  = PCSrcE;
        sf  = !PCSrcE && mdl_load_use();
        fe  = PCSrcE || mdl_load_use();
        s16 = sat(mdl_stalls, 65535);
        f16 = sat(mdl_flushes, 65535);
        s4  = sat(mdl_stalls, 15);
        f4  = sat(mdl_flushes, 15);
        return {fa, fb, sf, sf, fd, fe, 16'(s16), 16'(f16),
                fa, fb, sf, sf, fd, fe, 4'(s4), 4'(f4)};
    endfunction

    function automatic logic [55:0] observed();
        return {ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, stall_cnt, flush_cnt,
                fa4, fb4, sf4, sd4, fd4, fe4, stall_cnt4, flush_cnt4};
    endfunction

    task automatic model_edge();
        writer_t w;
        logic    flush_e;
        if (rst) begin
            writers = {};
            writers.push_back('0);
            writers.push_back('0);
            mdl_prev_flush = 1'b0;
            mdl_stalls     = 0;
            mdl_flushes    = 0;
        end else begin
            flush_e = PCSrcE || mdl_load_use();
            w.wr = RegWriteE && !mdl_prev_flush;
            w.rd = RdE;
            writers.push_front(w);
            void'(writers.pop_back());
            if (!PCSrcE && mdl_load_use()) mdl_stalls++;
            if (PCSrcE) mdl_flushes++;
            mdl_prev_flush = flush_e;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [4:0] rs1d, input logic [4:0] rs2d,
                         input logic [4:0] rs1e, input logic [4:0] rs2e,
                         input logic [4:0] rde, input logic rwe,
                         input logic lde, input logic pcs);
        Rs1D = rs1d; Rs2D = rs2d; Rs1E = rs1e; Rs2E = rs2e;
        RdE = rde; RegWriteE = rwe; LoadE = lde; PCSrcE = pcs;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [55:0] got;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'($urandom),
                  1'($urandom), 1'($urandom));
            @(negedge clk);
            got = observed();
            checks++;
            if (got !== 56'd0) begin
                errors++;
                $display("FAIL reset_outputs: got %h expected 0", got);
            end
            tick();
        end
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        got = observed();
        checks++;
        if (got !== mdl_expect()) begin
            errors++;
            $display("FAIL reset_release: got %h expected %h", got, mdl_expect());
        end
        tick();
    endtask

    task automatic test_forward();
        logic [55:0] got;
        // producer of x5 in Execute
        drive(0, 0, 0, 0, 5, 1, 0, 0);
        @(negedge clk);
        got = observed();
        checks++;
        if (got !== mdl_expect()) begin
            errors++;
            $display("FAIL fwd_producer: got %h expected %h", got, mdl_expect());
        end
        tick();
        // consumer one behind: from Memory
        drive(0, 0, 5, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (ForwardAE !== 2'b10) begin
            errors++;
            $display("FAIL fwd_a_mem: got %b expected 10", ForwardAE);
        end
        tick();
        // consumer two behind: from Writeback
        drive(0, 0, 5, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (ForwardAE !== 2'b01) begin
            errors++;
            $display("FAIL fwd_a_wb: got %b expected 01", ForwardAE);
        end
        tick();
        // x7 in both Memory and Writeback; x0 also written
        drive(0, 0, 0, 0, 7, 1, 0, 0);
        tick();
        drive(0, 0, 0, 0, 7, 1, 0, 0);
        tick();
        drive(0, 0, 0, 7, 0, 1, 0, 0);
        @(negedge clk);
        checks++;
        if (ForwardBE !== 2'b10) begin
            errors++;
            $display("FAIL fwd_b_mem_priority: got %b expected 10", ForwardBE);
        end
        checks++;
        if (ForwardAE !== 2'b00) begin
            errors++;
            $display("FAIL fwd_a_x0: got %b expected 00", ForwardAE);
        end
        tick();
        // x0 load never stalls, x0 writer never forwards
        drive(0, 0, 0, 0, 0, 1, 1, 0);
        @(negedge clk);
        checks++;
        if (StallF !== 1'b0 || ForwardAE !== 2'b00 || ForwardBE !== 2'b00) begin
            errors++;
            $display("FAIL x0_no_hazard: got stall=%b fa=%b fb=%b expected 0 00 00",
                     StallF, ForwardAE, ForwardBE);
        end
        tick();
    endtask

    task automatic test_load_use();
        logic [55:0] got;
        drive(0, 3, 0, 0, 3, 1, 1, 0);
        @(negedge clk);
        checks++;
        if ({StallF, StallD, FlushE, FlushD} !== 4'b1110) begin
            errors++;
            $display("FAIL load_use_stall: got %b expected 1110", {StallF, StallD, FlushE, FlushD});
        end
        tick();
        // bubble in Execute, dependent still in Decode
        drive(0, 3, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (StallF !== 1'b0 || stall_cnt !== 16'd1) begin
            errors++;
            $display("FAIL load_use_after: got stall=%b cnt=%0d expected 0 1", StallF, stall_cnt);
        end
        got = observed();
        checks++;
        if (got !== mdl_expect()) begin
            errors++;
            $display("FAIL load_use_model: got %h expected %h", got, mdl_expect());
        end
        tick();
        // dependent in Execute, load in Writeback
        drive(0, 0, 0, 3, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (ForwardBE !== 2'b01) begin
            errors++;
            $display("FAIL load_use_fwd: got %b expected 01", ForwardBE);
        end
        tick();
    endtask

    task automatic test_redirect();
        logic [55:0] got;
        drive(3, 0, 0, 0, 3, 1, 1, 1);
        @(negedge clk);
        checks++;
        if ({FlushD, FlushE, StallF, StallD} !== 4'b1100) begin
            errors++;
            $display("FAIL redirect_wins: got %b expected 1100", {FlushD, FlushE, StallF, StallD});
        end
        tick();
        // squashed slot in Execute pretends to write x9
        drive(0, 0, 0, 0, 9, 1, 0, 0);
        @(negedge clk);
        checks++;
        if (flush_cnt !== 16'd1 || StallF !== 1'b0) begin
            errors++;
            $display("FAIL redirect_count: got cnt=%0d stall=%b expected 1 0", flush_cnt, StallF);
        end
        tick();
        drive(0, 0, 9, 9, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (ForwardAE !== 2'b00 || ForwardBE !== 2'b00) begin
            errors++;
            $display("FAIL squashed_no_fwd: got %b %b expected 00 00", ForwardAE, ForwardBE);
        end
        got = observed();
        checks++;
        if (got !== mdl_expect()) begin
            errors++;
            $display("FAIL redirect_model: got %h expected %h", got, mdl_expect());
        end
        tick();
    endtask

    task automatic test_saturation();
        logic [55:0] got;
        for (int i = 0; i < 20; i++) begin
            drive(4, 0, 0, 0, 4, 1, 1, 0);
            @(negedge clk);
            got = observed();
            checks++;
            if (got !== mdl_expect()) begin
                errors++;
                $display("FAIL sat_cycle%0d: got %h expected %h", i, got, mdl_expect());
            end
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (stall_cnt4 !== 4'hF) begin
            errors++;
            $display("FAIL sat_hold: got %0d expected 15", stall_cnt4);
        end
        tick();
    endtask

    task automatic test_reset_mid_stall();
        logic [55:0] got;
        drive(0, 0, 0, 0, 6, 1, 0, 0);
        tick();
        drive(6, 0, 0, 0, 6, 1, 1, 0);
        @(negedge clk);
        checks++;
        if (StallF !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_stall: got %b expected 1", StallF);
        end
        rst = 1'b1;
        #1;
        got = observed();
        checks++;
        if (got !== 56'd0) begin
            errors++;
            $display("FAIL reset_mid_stall: got %h expected 0", got);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 6, 6, 0, 0, 0, 0);
            @(negedge clk);
            checks++;
            if (ForwardAE !== 2'b00 || ForwardBE !== 2'b00) begin
                errors++;
                $display("FAIL post_reset_fwd%0d: got %b %b expected 00 00", i, ForwardAE, ForwardBE);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [55:0] got;
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            drive(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) == 0));
            @(negedge clk);
            got = observed();
            checks++;
            if (got !== mdl_expect()) begin
                errors++;
                $display("FAIL random_cycle%0d: got %h expected %h", i, got, mdl_expect());
            end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        writers = {};
        writers.push_back('0);
        writers.push_back('0);
        mdl_prev_flush = 1'b0;
        mdl_stalls     = 0;
        mdl_flushes    = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        test_reset();
        test_forward();
        test_load_use();
        test_redirect();
        test_saturation();
        test_reset_mid_stall();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, giving the width of each event counter.
REQ-002 Port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-003 Port rst, input, 1: reset, synchronous and active-high.
REQ-004 Port Rs1D, input, 5: rs1 field of the instruction in Decode.
REQ-005 Port Rs2D, input, 5: rs2 field of the instruction in Decode.
REQ-006 Port Rs1E, input, 5: rs1 of the instruction in Execute.
REQ-007 Port Rs2E, input, 5: rs2 of the instruction in Execute.
REQ-008 Port RdE, input, 5: destination register of the instruction in Execute.
REQ-009 Port RegWriteE, input, 1: the Execute instruction writes RdE.
REQ-010 Port LoadE, input, 1: the Execute instruction is a load (result available only after Memory).
REQ-011 Port PCSrcE, input, 1: the taken-branch/jump select from Execute (branch AND zero, OR jump).
REQ-012 Port ForwardAE, output, 2: select for operand-A mux: 00 = RD1, 01 = resultW, 10 = ALU result in Memory.
REQ-013 Port ForwardBE, output, 2: same encoding for operand-B mux.
REQ-014 Ports StallF and StallD, output, 1 each: hold the PC register and the IF/ID register.
REQ-015 Ports FlushD and FlushE, output, 1 each: clear IF/ID and ID/EX to a bubble on the next edge.
REQ-016 Ports stall_cnt and flush_cnt, output, CNT_W each: performance counters.

Function
REQ-017 The block SHALL keep internal shadow state {RdM, RegWriteM} <= {RdE, RegWriteE} and {RdW, RegWriteW} <= {RdM, RegWriteM} on every edge; the EX/MEM and MEM/WB stages never stall.
REQ-018 If FlushE was high on the previous edge, the shadow M entry SHALL load RegWriteM = 0, so a squashed Execute slot never forwards.
REQ-019 ForwardAE SHALL be 10 when RegWriteM, RdM != 0 and RdM == Rs1E; else 01 when RegWriteW, RdW != 0 and RdW == Rs1E; else 00. Memory has priority over Writeback.
REQ-020 ForwardBE SHALL follow the REQ-019 rule using Rs2E.
REQ-021 Register x0 SHALL never be forwarded and SHALL never cause a stall.
REQ-022 lwStall = LoadE & RegWriteE & (RdE != 0) & (RdE == Rs1D | RdE == Rs2D).
REQ-023 When lwStall is high and PCSrcE is low: StallF = StallD = 1, FlushE = 1, FlushD = 0; exactly one bubble is inserted.
REQ-024 When PCSrcE is high: FlushD = FlushE = 1 and StallF = StallD = 0, regardless of lwStall, because the redirect wins.
REQ-025 Forward, stall and flush outputs SHALL be combinational from the current inputs and registered shadow state, with zero-cycle latency.
REQ-026 stall_cnt SHALL increment by 1 on each edge where StallF is high.
REQ-027 flush_cnt SHALL increment by 1 on each edge where PCSrcE is high.
REQ-028 Both counters SHALL saturate at all-ones and not wrap.

Reset
REQ-029 While rst is high, every output SHALL be 0 (ForwardAE/BE = 00, stalls 0, flushes 0).
REQ-030 On an edge with rst high, the shadow registers SHALL clear (RegWriteM = RegWriteW = 0, RdM = RdW = 0), the previous-flush flag SHALL clear, and both counters SHALL clear.
REQ-031 Reset asserted mid-stall SHALL drop the stall on the same cycle, and no forward SHALL come from pre-reset instructions after release.

Structure
REQ-032 The forward-select encodings (RD1/W/M) and the x0 constant SHALL live in the shared pipeline package, and the EX operand muxes SHALL use the same package.
REQ-033 A sub-module fwd_sel (RdM, RegWriteM, RdW, RegWriteW, RsE -> 2-bit select) SHALL be instantiated twice, once for A and once for B; everything else stays flat.

Verification
REQ-034 Cycle n: RdE = 5, RegWriteE = 1. Cycle n+1: Rs1E = 5 -> ForwardAE = 10. Cycle n+2: Rs1E = 5 -> ForwardAE = 01.
REQ-035 Memory and Writeback both hold Rd = 7 with RegWrite = 1, Rs2E = 7 -> ForwardBE = 10 (Memory priority). Any case with Rs1E = 0 -> ForwardAE = 00.
REQ-036 LoadE = 1, RdE = 3, Rs2D = 3 -> one cycle of StallF = StallD = FlushE = 1. The next cycle has no stall, stall_cnt = 1, and the load then forwards 01.
REQ-037 lwStall and PCSrcE high together -> FlushD = FlushE = 1, StallF = 0, flush_cnt = 1. Next cycle: RegWriteM = 0 and no forward from the squashed slot.
REQ-038 Counters preloaded near saturation (CNT_W = 4) with 20 stall cycles -> stall_cnt holds 15.
REQ-039 rst pulsed during a load-use stall -> outputs 0 while rst is high. After release: ForwardAE/BE = 00 even when Rs1E/Rs2E equal the old RdM.
